// File: rtl/receptor_pkg.sv
// receptor_pkg: lane count, lane state type and default receptor geometry
package receptor_pkg;
    localparam int NUM_LANES = 4;
    localparam logic [9:0] DEF_LANE_X0 = 10'd200;
    localparam logic [9:0] DEF_LANE_W = 10'd48;
    localparam logic [9:0] DEF_LANE_GAP = 10'd16;
    localparam logic [9:0] DEF_RECEPTOR_Y = 10'd400;
    localparam logic [9:0] DEF_RECEPTOR_H = 10'd48;
    typedef enum logic [1:0] {IDLE, FLASH, HOLD} lane_state_t;
    // Widened to 11 bits so edge sums past 1023 cannot wrap.
    function automatic logic [10:0] lane_left(input int i, input logic [9:0] x0, input logic [9:0] w, input logic [9:0] gap);
        return 11'(x0) + 11'(i) * (11'(w) + 11'(gap));
    endfunction
endpackage

// File: rtl/receptor_lanes_if.sv
// receptor_lanes_if: key/frame/pixel inputs and receptor hit/press outputs
interface receptor_lanes_if;
    import receptor_pkg::*;
    logic frame_clk;
    logic [NUM_LANES-1:0] key_down;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [NUM_LANES-1:0] is_receptor;
    logic is_receptor_background;
    logic [NUM_LANES-1:0] press_pulse;
    modport master (output frame_clk, key_down, DrawX, DrawY, input is_receptor, is_receptor_background, press_pulse);
    modport slave (input frame_clk, key_down, DrawX, DrawY, output is_receptor, is_receptor_background, press_pulse);
endinterface

// File: rtl/lane_fsm.sv
// lane_fsm: per-lane IDLE/FLASH/HOLD machine timed in frame ticks
module lane_fsm import receptor_pkg::*; #(
    parameter int FLASH_FRAMES = 6
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic key,
    input  logic rise,
    input  logic frame_tick,
    output logic lit,
    output logic press
);
    localparam int CW = $clog2(FLASH_FRAMES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(FLASH_FRAMES);
    lane_state_t state;
    logic [CW-1:0] cnt;
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                IDLE: if (rise) begin
                    state <= FLASH;
                    cnt <= RELOAD;
                    press <= 1'b1;
                end
                // A re-press restarts the flash and swallows a coincident tick.
                FLASH: if (rise) begin
                    cnt <= RELOAD;
                    press <= 1'b1;
                end else if (frame_tick) begin
                    if (cnt == CW'(1)) begin
                        state <= key ? HOLD : IDLE;
                        cnt <= '0;
                    end else cnt <= cnt - 1'b1;
                end
                HOLD: if (!key) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign lit = state != IDLE;
endmodule

// File: rtl/receptor_lanes.sv
// receptor_lanes: frame-tick sync, key edge detect, four lane FSMs and registered pixel hits
module receptor_lanes import receptor_pkg::*; #(
    parameter logic [9:0] LANE_X0 = DEF_LANE_X0,
    parameter logic [9:0] LANE_W = DEF_LANE_W,
    parameter logic [9:0] LANE_GAP = DEF_LANE_GAP,
    parameter logic [9:0] RECEPTOR_Y = DEF_RECEPTOR_Y,
    parameter logic [9:0] RECEPTOR_H = DEF_RECEPTOR_H,
    parameter int FLASH_FRAMES = 6
) (
    input logic Clk,
    input logic Reset_n,
    receptor_lanes_if.slave bus
);
    localparam logic [10:0] STRIP_L = 11'(LANE_X0);
    localparam logic [10:0] STRIP_R = lane_left(NUM_LANES - 1, LANE_X0, LANE_W, LANE_GAP) + 11'(LANE_W);
    localparam logic [10:0] BOX_T = 11'(RECEPTOR_Y);
    localparam logic [10:0] BOX_B = 11'(RECEPTOR_Y) + 11'(RECEPTOR_H);
    logic [2:0] fsync;
    logic frame_tick;
    logic [NUM_LANES-1:0] key_hist, rise, lit, press, in_box;
    logic [10:0] x, y;
    logic in_y, in_strip;
    // fsync = {history, sync2, sync1}; all set on reset so a high frame_clk is not a tick.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fsync <= 3'b111;
            key_hist <= '0;
            rise <= '0;
        end else begin
            fsync <= {fsync[1:0], bus.frame_clk};
            rise <= bus.key_down & ~key_hist;
            key_hist <= bus.key_down;
        end
    end
    assign frame_tick = fsync[1] & ~fsync[2];
    assign x = 11'(bus.DrawX);
    assign y = 11'(bus.DrawY);
    assign in_y = (y >= BOX_T) && (y < BOX_B);
    assign in_strip = (x >= STRIP_L) && (x < STRIP_R);
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam logic [10:0] LEFT = lane_left(g, LANE_X0, LANE_W, LANE_GAP);
        lane_fsm #(.FLASH_FRAMES(FLASH_FRAMES)) u_lane (
            .Clk(Clk),
            .Reset_n(Reset_n),
            .key(bus.key_down[g]),
            .rise(rise[g]),
            .frame_tick(frame_tick),
            .lit(lit[g]),
            .press(press[g])
        );
        assign in_box[g] = (x >= LEFT) && (x < LEFT + 11'(LANE_W)) && in_y;
    end
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.is_receptor <= '0;
            bus.is_receptor_background <= 1'b0;
        end else begin
            bus.is_receptor <= in_box & lit;
            bus.is_receptor_background <= in_strip;
        end
    end
    assign bus.press_pulse = press;
endmodule

// File: tb/tb_receptor_lanes.sv
// tb_receptor_lanes: scoreboard bench, expectations queued by cycle and checked by a negedge monitor
module tb_receptor_lanes;
    import receptor_pkg::*;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    receptor_lanes_if bus();
    receptor_lanes dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));
    typedef struct {
        int at;
        string name;
        logic [3:0] rec;
        logic bg;
        logic [3:0] press;
    } exp_t;
    exp_t sb[$];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [9:0] sx [15] = '{200, 199, 247, 248, 263, 264, 311, 312, 439, 440, 220, 220, 220, 220, 360};
    logic [9:0] sy [15] = '{410, 410, 410, 410, 410, 410, 410, 410, 410, 410, 399, 400, 447, 448, 600};
    logic [3:0] sr [15] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                            4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic sb_bg [15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    always @(posedge clk) cyc <= cyc + 1;
    task automatic expect_at(input int at, input string name, input logic [3:0] rec, input logic bg, input logic [3:0] press);
        exp_t e;
        e.at = at;
        e.name = name;
        e.rec = rec;
        e.bg = bg;
        e.press = press;
        sb.push_back(e);
    endtask
    always @(negedge clk) begin : monitor
        bit matched;
        matched = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                n_checks++;
                if (sb[i].at == cyc) matched = 1'b1;
                if (sb[i].at != cyc || bus.is_receptor !== sb[i].rec || bus.is_receptor_background !== sb[i].bg || bus.press_pulse !== sb[i].press) begin
                    n_fail++;
                    $display("FAIL %s @cycle %0d (due %0d): got is_receptor=%b bg=%b press=%b, expected is_receptor=%b bg=%b press=%b",
                             sb[i].name, cyc, sb[i].at, bus.is_receptor, bus.is_receptor_background, bus.press_pulse, sb[i].rec, sb[i].bg, sb[i].press);
                end
                sb.delete(i);
            end
        end
        if (bus.press_pulse !== 4'b0000) begin
            n_checks++;
            if (!matched) begin
                n_fail++;
                $display("FAIL unexpected_press @cycle %0d: got press=%b, expected 0000", cyc, bus.press_pulse);
            end
        end
    end
    task automatic frame_pulse();
        bus.frame_clk = 1'b1;
        repeat (3) @(negedge clk);
        bus.frame_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask
    // Six frame pulses; lane lit through tick 5, shows fin one cycle after tick 6 takes effect.
    task automatic run_flash(input string tag, input logic [3:0] lit, input logic [3:0] fin);
        int p;
        for (int k = 1; k <= 6; k++) begin
            p = cyc;
            if (k == 5) expect_at(p + 4, {tag, "_tick5"}, lit, 1'b1, 4'b0000);
            if (k == 6) begin
                expect_at(p + 3, {tag, "_tick6_edge"}, lit, 1'b1, 4'b0000);
                expect_at(p + 4, {tag, "_after_tick6"}, fin, 1'b1, 4'b0000);
            end
            frame_pulse();
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
    initial begin
        int c;
        rst_n = 1'b0;
        bus.frame_clk = 1'b1;
        bus.key_down = 4'b1111;
        bus.DrawX = 10'd220;
        bus.DrawY = 10'd410;
        @(negedge clk);
        c = cyc;
        for (int i = 1; i <= 4; i++) expect_at(c + i, "reset", 4'b0000, 1'b0, 4'b0000);
        repeat (4) begin
            bus.frame_clk = ~bus.frame_clk;
            @(negedge clk);
        end
        // Release with frame_clk high and key 0 already held.
        c = cyc;
        rst_n = 1'b1;
        bus.key_down = 4'b0001;
        expect_at(c + 1, "release_idle", 4'b0000, 1'b1, 4'b0000);
        expect_at(c + 2, "key0_press", 4'b0000, 1'b1, 4'b0001);
        expect_at(c + 3, "key0_lit", 4'b0001, 1'b1, 4'b0000);
        @(negedge clk);
        bus.key_down = 4'b0000;
        repeat (2) @(negedge clk);
        bus.frame_clk = 1'b0;
        repeat (2) @(negedge clk);
        run_flash("key0", 4'b0001, 4'b0000);
        c = cyc;
        bus.key_down = 4'b0100;
        bus.DrawX = 10'd328;
        expect_at(c + 2, "key2_press", 4'b0000, 1'b1, 4'b0100);
        expect_at(c + 3, "key2_lit", 4'b0100, 1'b1, 4'b0000);
        repeat (3) @(negedge clk);
        bus.DrawX = 10'd376;
        expect_at(cyc + 1, "gap_376", 4'b0000, 1'b1, 4'b0000);
        @(negedge clk);
        bus.DrawX = 10'd375;
        expect_at(cyc + 1, "lane2_right_375", 4'b0100, 1'b1, 4'b0000);
        @(negedge clk);
        c = cyc;
        bus.key_down = 4'b1000;
        bus.DrawX = 10'd400;
        expect_at(c + 2, "key3_press", 4'b0000, 1'b1, 4'b1000);
        expect_at(c + 3, "key3_lit", 4'b1000, 1'b1, 4'b0000);
        repeat (3) @(negedge clk);
        run_flash("key3_hold", 4'b1000, 4'b1000);
        c = cyc;
        expect_at(c + 1, "hold_lit", 4'b1000, 1'b1, 4'b0000);
        expect_at(c + 2, "hold_released", 4'b0000, 1'b1, 4'b0000);
        bus.key_down = 4'b0000;
        repeat (3) @(negedge clk);
        c = cyc;
        bus.key_down = 4'b0010;
        bus.DrawX = 10'd270;
        expect_at(c + 2, "key1_press", 4'b0000, 1'b1, 4'b0010);
        expect_at(c + 3, "key1_lit", 4'b0010, 1'b1, 4'b0000);
        repeat (3) @(negedge clk);
        // Release/re-press timed so the new rise meets the frame tick at the lane.
        c = cyc;
        bus.frame_clk = 1'b1;
        bus.key_down = 4'b0000;
        expect_at(c + 3, "key1_repress", 4'b0010, 1'b1, 4'b0010);
        expect_at(c + 4, "key1_repress_end", 4'b0010, 1'b1, 4'b0000);
        @(negedge clk);
        bus.key_down = 4'b0010;
        @(negedge clk);
        bus.key_down = 4'b0000;
        @(negedge clk);
        bus.frame_clk = 1'b0;
        repeat (3) @(negedge clk);
        run_flash("key1_reload", 4'b0010, 4'b0000);
        c = cyc;
        bus.key_down = 4'b1111;
        bus.DrawX = 10'd200;
        expect_at(c + 2, "all_press", 4'b0000, 1'b1, 4'b1111);
        expect_at(c + 3, "all_lit", 4'b0001, 1'b1, 4'b0000);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            bus.DrawX = sx[i];
            bus.DrawY = sy[i];
            expect_at(cyc + 1, $sformatf("sweep_x%0d_y%0d", sx[i], sy[i]), sr[i], sb_bg[i], 4'b0000);
            @(negedge clk);
        end
        rst_n = 1'b0;
        bus.DrawX = 10'd220;
        bus.DrawY = 10'd410;
        expect_at(cyc + 1, "reset_mid_flash", 4'b0000, 1'b0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        bus.key_down = 4'b0000;
        expect_at(cyc + 1, "after_reset", 4'b0000, 1'b1, 4'b0000);
        expect_at(cyc + 2, "after_reset_idle", 4'b0000, 1'b1, 4'b0000);
        repeat (4) @(negedge clk);
        foreach (sb[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked, due cycle %0d, now %0d", sb[i].name, sb[i].at, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
